// File: rtl/uart_core_param.sv
// uart_core_param: parametrised full-duplex UART with valid/ready handshakes.
//
// Ports:
//   clk, rst                        system clock, synchronous active-high reset
//   tx_data, tx_valid, tx_ready     transmit handshake; accept on tx_valid && tx_ready
//   txd                             serial output, idle high
//   rxd                             serial input (asynchronous)
//   rx_data, rx_perr, rx_ferr,
//   rx_break, rx_valid, rx_ready    head of the receive FIFO; pop on rx_valid && rx_ready
//   rx_overrun                      sticky dropped-character flag, cleared by a pop
//
// TX states                 RX states
//   state   | meaning         state   | meaning
//   T_IDLE  | ready, line high R_IDLE  | waiting for a filtered falling edge
//   T_START | start bit       R_START | checking the start bit at mid-bit
//   T_DATA  | data, LSB first R_DATA  | sampling data bits
//   T_PAR   | parity bit      R_PAR   | sampling the parity bit
//   T_STOP  | stop bit(s)     R_STOP  | sampling the stop bit, pushing the entry
//                             R_WAIT  | framing error, waiting for the line to go high
module uart_core_param #(
    parameter int CLK_FREQ      = 25000000,
    parameter int BAUD          = 115200,
    parameter int OVERSAMPLE    = 16,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_break,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_overrun
);

    localparam int DIV_RAW = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(DATA_BITS);
    localparam int AW      = $clog2(RX_FIFO_DEPTH);
    localparam int NW      = AW + 1;
    localparam int EW      = DATA_BITS + 3;

    // ---------------- shared oversampling prescaler ----------------
    logic [PW-1:0] presc_q;
    logic          tick;

    assign tick = (presc_q == '0);

    always_ff @(posedge clk) begin
        if (rst)       presc_q <= '0;
        else if (tick) presc_q <= PW'(DIV - 1);
        else           presc_q <= presc_q - PW'(1);
    end

    // ---------------- transmitter ----------------
    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_e;

    tx_state_e            tx_state_q;
    logic [DATA_BITS-1:0] tx_sh_q;
    logic [CW-1:0]        tx_cnt_q;
    logic [BW-1:0]        tx_bit_q;
    logic                 tx_par_q;
    logic                 tx_stop_q;
    logic                 txd_q;
    logic                 tx_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= T_IDLE;
            tx_sh_q    <= '0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_par_q   <= 1'b0;
            tx_stop_q  <= 1'b0;
            txd_q      <= 1'b1;
            tx_ready_q <= 1'b1;
        end else if (tx_state_q == T_IDLE) begin
            // tx_ready_q is always high in T_IDLE, so tx_valid alone means accept
            if (tx_valid) begin
                tx_sh_q    <= tx_data;
                tx_par_q   <= (PARITY == 1) ? ~^tx_data : ^tx_data;
                tx_cnt_q   <= CW'(OVERSAMPLE - 1);
                txd_q      <= 1'b0;
                tx_ready_q <= 1'b0;
                tx_state_q <= T_START;
            end
        end else if (tick) begin
            if (tx_cnt_q != '0) begin
                tx_cnt_q <= tx_cnt_q - CW'(1);
            end else begin
                tx_cnt_q <= CW'(OVERSAMPLE - 1);
                case (tx_state_q)
                    T_START: begin
                        txd_q      <= tx_sh_q[0];
                        tx_bit_q   <= BW'(DATA_BITS - 1);
                        tx_state_q <= T_DATA;
                    end
                    T_DATA: begin
                        if (tx_bit_q == '0) begin
                            if (PARITY != 0) begin
                                txd_q      <= tx_par_q;
                                tx_state_q <= T_PAR;
                            end else begin
                                txd_q      <= 1'b1;
                                tx_stop_q  <= 1'(STOP_BITS - 1);
                                tx_state_q <= T_STOP;
                            end
                        end else begin
                            tx_sh_q  <= {1'b0, tx_sh_q[DATA_BITS-1:1]};
                            txd_q    <= tx_sh_q[1];
                            tx_bit_q <= tx_bit_q - BW'(1);
                        end
                    end
                    T_PAR: begin
                        txd_q      <= 1'b1;
                        tx_stop_q  <= 1'(STOP_BITS - 1);
                        tx_state_q <= T_STOP;
                    end
                    T_STOP: begin
                        if (tx_stop_q == 1'b0) begin
                            tx_ready_q <= 1'b1;
                            tx_state_q <= T_IDLE;
                        end else begin
                            tx_stop_q <= 1'b0;
                        end
                    end
                    default: tx_state_q <= T_IDLE;
                endcase
            end
        end
    end

    assign txd      = txd_q;
    assign tx_ready = tx_ready_q;

    // ---------------- receiver ----------------
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT} rx_state_e;

    rx_state_e            rx_state_q;
    logic [1:0]           sync_q;
    logic [1:0]           samp_q;
    logic                 filt_q;
    logic                 filt_d;
    logic [CW-1:0]        rx_cnt_q;
    logic [BW-1:0]        rx_bit_q;
    logic [DATA_BITS-1:0] rx_sh_q;
    logic                 rx_par_q;
    logic                 push_q;
    logic [EW-1:0]        push_ent_q;
    logic                 rx_par_exp;

    // majority of the current synchronised sample and the two previous tick samples
    assign filt_d = (samp_q[1] & samp_q[0]) | (samp_q[1] & sync_q[1]) | (samp_q[0] & sync_q[1]);
    assign rx_par_exp = (PARITY == 1) ? ~^rx_sh_q : ^rx_sh_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= R_IDLE;
            sync_q     <= 2'b11;
            samp_q     <= 2'b11;
            filt_q     <= 1'b1;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_par_q   <= 1'b0;
            push_q     <= 1'b0;
            push_ent_q <= '0;
        end else begin
            sync_q <= {sync_q[0], rxd};
            push_q <= 1'b0;
            if (tick) begin
                samp_q <= {samp_q[0], sync_q[1]};
                filt_q <= filt_d;
                case (rx_state_q)
                    R_IDLE: begin
                        if (filt_q && !filt_d) begin
                            rx_cnt_q   <= CW'(OVERSAMPLE / 2 - 1);
                            rx_state_q <= R_START;
                        end
                    end
                    R_WAIT: begin
                        if (filt_d) rx_state_q <= R_IDLE;
                    end
                    default: begin
                        if (rx_cnt_q != '0) begin
                            rx_cnt_q <= rx_cnt_q - CW'(1);
                        end else begin
                            rx_cnt_q <= CW'(OVERSAMPLE - 1);
                            case (rx_state_q)
                                R_START: begin
                                    if (filt_d) begin
                                        rx_state_q <= R_IDLE;
                                    end else begin
                                        rx_bit_q   <= BW'(DATA_BITS - 1);
                                        rx_state_q <= R_DATA;
                                    end
                                end
                                R_DATA: begin
                                    rx_sh_q <= {filt_d, rx_sh_q[DATA_BITS-1:1]};
                                    if (rx_bit_q == '0)
                                        rx_state_q <= (PARITY != 0) ? R_PAR : R_STOP;
                                    else
                                        rx_bit_q <= rx_bit_q - BW'(1);
                                end
                                R_PAR: begin
                                    rx_par_q   <= filt_d;
                                    rx_state_q <= R_STOP;
                                end
                                R_STOP: begin
                                    push_q     <= 1'b1;
                                    push_ent_q <= {rx_sh_q,
                                                   (PARITY != 0) && (rx_par_q != rx_par_exp),
                                                   !filt_d,
                                                   !filt_d && (rx_sh_q == '0) && ((PARITY == 0) || !rx_par_q)};
                                    rx_state_q <= filt_d ? R_IDLE : R_WAIT;
                                end
                                default: rx_state_q <= R_IDLE;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- receive FIFO ----------------
    logic [EW-1:0] fifo_mem [RX_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [NW-1:0] fifo_cnt_q;
    logic          overrun_q;
    logic          pop;
    logic          push_ok;
    logic [EW-1:0] head;

    assign pop     = rx_ready && (fifo_cnt_q != '0);
    // a pop in the same cycle frees the slot a full FIFO would otherwise deny
    assign push_ok = push_q && ((fifo_cnt_q != NW'(RX_FIFO_DEPTH)) || pop);

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= push_ent_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_ok && !pop)      fifo_cnt_q <= fifo_cnt_q + NW'(1);
            else if (pop && !push_ok) fifo_cnt_q <= fifo_cnt_q - NW'(1);
            if (pop)                  overrun_q <= 1'b0;
            else if (push_q && !push_ok) overrun_q <= 1'b1;
        end
    end

    assign head       = fifo_mem[rd_ptr_q];
    assign rx_valid   = (fifo_cnt_q != '0);
    assign rx_data    = rx_valid ? head[EW-1:3] : '0;
    assign rx_perr    = rx_valid & head[2];
    assign rx_ferr    = rx_valid & head[1];
    assign rx_break   = rx_valid & head[0];
    assign rx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_core_param.sv
module tb_uart_core_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // instance A: 8N1, depth 4
    logic [7:0] tx_data_a, rx_data_a;
    logic tx_valid_a, tx_ready_a, txd_a, rxd_a, rxd_drv_a, loop_a;
    logic rx_perr_a, rx_ferr_a, rx_break_a, rx_valid_a, rx_ready_a, rx_overrun_a;
    assign rxd_a = loop_a ? txd_a : rxd_drv_a;

    // instance B: 7 data bits, even parity, 2 stop bits
    logic [6:0] tx_data_b, rx_data_b;
    logic tx_valid_b, tx_ready_b, txd_b, rxd_b, rxd_drv_b, loop_b;
    logic rx_perr_b, rx_ferr_b, rx_break_b, rx_valid_b, rx_ready_b, rx_overrun_b;
    assign rxd_b = loop_b ? txd_b : rxd_drv_b;

    uart_core_param #(
        .CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLE(16), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .RX_FIFO_DEPTH(4)
    ) u_a (
        .clk(clk), .rst(rst), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready_a), .txd(txd_a), .rxd(rxd_a), .rx_data(rx_data_a),
        .rx_perr(rx_perr_a), .rx_ferr(rx_ferr_a), .rx_break(rx_break_a),
        .rx_valid(rx_valid_a), .rx_ready(rx_ready_a), .rx_overrun(rx_overrun_a)
    );

    uart_core_param #(
        .CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLE(16), .DATA_BITS(7),
        .PARITY(2), .STOP_BITS(2), .RX_FIFO_DEPTH(4)
    ) u_b (
        .clk(clk), .rst(rst), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .txd(txd_b), .rxd(rxd_b), .rx_data(rx_data_b),
        .rx_perr(rx_perr_b), .rx_ferr(rx_ferr_b), .rx_break(rx_break_b),
        .rx_valid(rx_valid_b), .rx_ready(rx_ready_b), .rx_overrun(rx_overrun_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] frame8(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    // Called at a negedge with the transmitter idle; pat lists line levels in time order.
    task automatic tx_and_check(input bit sel, input logic [7:0] d, input logic [15:0] pat, input int nbits);
        logic [15:0] got;
        got = '0;
        if (sel) begin tx_data_b = d[6:0]; tx_valid_b = 1'b1; end
        else     begin tx_data_a = d;      tx_valid_a = 1'b1; end
        @(negedge clk);
        tx_valid_a = 1'b0;
        tx_valid_b = 1'b0;
        chk("tx_ready_drop", 32'(sel ? tx_ready_b : tx_ready_a), 32'd0);
        for (int i = 0; i < nbits; i++) begin
            for (int s = 0; s < 16; s++) begin
                if (i != 0 || s != 0) @(negedge clk);
                got[s] = sel ? txd_b : txd_a;
            end
            chk($sformatf("txd_bit%0d", i), 32'(got), 32'({16{pat[i]}}));
        end
        chk("tx_ready_in_stop", 32'(sel ? tx_ready_b : tx_ready_a), 32'd0);
        @(negedge clk);
        chk("tx_ready_rise", 32'(sel ? tx_ready_b : tx_ready_a), 32'd1);
    endtask

    task automatic rx_bits(input bit sel, input logic [15:0] pat, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (sel) rxd_drv_b = pat[i]; else rxd_drv_a = pat[i];
            repeat (16) @(negedge clk);
        end
        rxd_drv_a = 1'b1;
        rxd_drv_b = 1'b1;
    endtask

    task automatic wait_rx(input bit sel, input string tag);
        int n;
        n = 0;
        while (!(sel ? rx_valid_b : rx_valid_a) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(sel ? rx_valid_b : rx_valid_a), 32'd1);
    endtask

    task automatic pop(input bit sel);
        if (sel) rx_ready_b = 1'b1; else rx_ready_a = 1'b1;
        @(negedge clk);
        rx_ready_a = 1'b0;
        rx_ready_b = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] q [3];
    int acc_t [3];
    int idx, cyc;

    initial begin
        rst = 1'b1;
        tx_data_a = '0; tx_valid_a = 1'b0; rxd_drv_a = 1'b1; loop_a = 1'b0; rx_ready_a = 1'b0;
        tx_data_b = '0; tx_valid_b = 1'b0; rxd_drv_b = 1'b1; loop_b = 1'b0; rx_ready_b = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        chk("rst_txd", 32'(txd_a), 32'd1);
        chk("rst_tx_ready", 32'(tx_ready_a), 32'd1);
        chk("rst_rx_valid", 32'(rx_valid_a), 32'd0);
        chk("rst_rx_data", 32'(rx_data_a), 32'd0);
        chk("rst_rx_flags", 32'({rx_perr_a, rx_ferr_a, rx_break_a, rx_overrun_a}), 32'd0);

        // 1: 8N1 0xA5 with loopback; frame 0,1,0,1,0,0,1,0,1,1 in time order
        loop_a = 1'b1;
        tx_and_check(1'b0, 8'hA5, 16'h034A, 10);
        wait_rx(1'b0, "a5_rx_valid");
        chk("a5_rx_data", 32'(rx_data_a), 32'hA5);
        chk("a5_rx_flags", 32'({rx_perr_a, rx_ferr_a, rx_break_a}), 32'd0);
        pop(1'b0);
        chk("a5_popped", 32'(rx_valid_a), 32'd0);

        // 2: 7E2 0x41: start, 1000001 LSB first, parity 0, stop, stop
        loop_b = 1'b1;
        tx_and_check(1'b1, 8'h41, 16'h0682, 11);
        wait_rx(1'b1, "b41_rx_valid");
        chk("b41_rx_data", 32'(rx_data_b), 32'h41);
        chk("b41_rx_perr", 32'(rx_perr_b), 32'd0);
        pop(1'b1);
        loop_b = 1'b0;
        rx_bits(1'b1, 16'h0782, 11);  // same frame with the parity bit flipped
        wait_rx(1'b1, "bperr_rx_valid");
        chk("bperr_rx_perr", 32'(rx_perr_b), 32'd1);
        chk("bperr_rx_data", 32'(rx_data_b), 32'h41);
        chk("bperr_rx_ferr", 32'(rx_ferr_b), 32'd0);
        pop(1'b1);

        // 3: long break gives exactly one entry; short glitch gives none
        loop_a = 1'b0;
        rxd_drv_a = 1'b0;
        repeat (200) @(negedge clk);
        rxd_drv_a = 1'b1;
        repeat (40) @(negedge clk);
        chk("brk_rx_valid", 32'(rx_valid_a), 32'd1);
        chk("brk_flags", 32'({rx_break_a, rx_ferr_a, rx_perr_a}), 32'b110);
        chk("brk_rx_data", 32'(rx_data_a), 32'd0);
        pop(1'b0);
        repeat (40) @(negedge clk);
        chk("brk_single_entry", 32'(rx_valid_a), 32'd0);
        rxd_drv_a = 1'b0;
        repeat (5) @(negedge clk);
        rxd_drv_a = 1'b1;
        repeat (300) @(negedge clk);
        chk("glitch_no_entry", 32'(rx_valid_a), 32'd0);

        // 4: overrun with five characters into a four-entry FIFO
        for (int k = 1; k <= 5; k++) rx_bits(1'b0, frame8(8'(k)), 10);
        repeat (10) @(negedge clk);
        chk("ovr_head", 32'(rx_data_a), 32'h01);
        chk("ovr_flag_set", 32'(rx_overrun_a), 32'd1);
        pop(1'b0);
        chk("ovr_head2", 32'(rx_data_a), 32'h02);
        chk("ovr_flag_clear", 32'(rx_overrun_a), 32'd0);
        pop(1'b0);
        chk("ovr_head3", 32'(rx_data_a), 32'h03);
        pop(1'b0);
        chk("ovr_head4", 32'(rx_data_a), 32'h04);
        pop(1'b0);
        chk("ovr_fifth_dropped", 32'(rx_valid_a), 32'd0);

        // 5: tx_valid held across three characters; accepts 161 clocks apart
        loop_a = 1'b1;
        q[0] = 8'h11; q[1] = 8'h22; q[2] = 8'h33;
        idx = 0; cyc = 0;
        tx_data_a = q[0];
        tx_valid_a = 1'b1;
        while (idx < 3 && cyc < 1000) begin
            if (tx_ready_a) begin
                acc_t[idx] = cyc;
                idx++;
            end
            @(negedge clk);
            cyc++;
            if (idx < 3) tx_data_a = q[idx]; else tx_valid_a = 1'b0;
        end
        tx_valid_a = 1'b0;
        chk("b2b_accepts", 32'(idx), 32'd3);
        chk("b2b_gap1", 32'(acc_t[1] - acc_t[0]), 32'd161);
        chk("b2b_gap2", 32'(acc_t[2] - acc_t[1]), 32'd161);
        repeat (170) @(negedge clk);
        chk("b2b_rx1", 32'(rx_data_a), 32'h11);
        pop(1'b0);
        chk("b2b_rx2", 32'(rx_data_a), 32'h22);
        pop(1'b0);
        chk("b2b_rx3", 32'(rx_data_a), 32'h33);

        // 6: reset mid-character (0x33 left in the FIFO)
        tx_data_a = 8'hC3;
        tx_valid_a = 1'b1;
        @(negedge clk);
        tx_valid_a = 1'b0;
        repeat (60) @(negedge clk);
        chk("pre_rst_txd", 32'(txd_a), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_txd", 32'(txd_a), 32'd1);
        chk("mid_rst_tx_ready", 32'(tx_ready_a), 32'd1);
        chk("mid_rst_rx_valid", 32'(rx_valid_a), 32'd0);
        repeat (20) @(negedge clk);
        chk("post_rst_no_entry", 32'(rx_valid_a), 32'd0);
        tx_and_check(1'b0, 8'h3C, frame8(8'h3C), 10);
        wait_rx(1'b0, "post_rst_rx_valid");
        chk("post_rst_rx_data", 32'(rx_data_a), 32'h3C);
        chk("post_rst_rx_flags", 32'({rx_perr_a, rx_ferr_a, rx_break_a, rx_overrun_a}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
